// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master sequencer: drives SCLK/CS_N and the load/shift strobes of an external shift register.
// Latency: start sampled in IDLE -> done pulse 2+CLK_DIV*(1+2N) cycles later; rx_data valid with done.
// Backpressure: none; start is ignored while busy (no queuing), re-sampled once IDLE is reached.
module spi_master_ctrl #(
    parameter int N       = 8,
    parameter int CLK_DIV = 2
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         start,
    input  logic         miso,
    input  logic [N-1:0] sr_q,
    output logic         sr_load,
    output logic         sr_shift,
    output logic         sr_sdatain,
    output logic         sclk,
    output logic         mosi,
    output logic         cs_n,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] rx_data
);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(N + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_END  = BW'(N);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SETUP = 3'd2,
        HIGH  = 3'd3,
        LOW   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] bit_inc;
    logic [BW-1:0] bit_nxt;
    logic [N-1:0]  rx_cap;

    // MSB of the shift register goes straight out, so data leaves MSB first
    assign mosi    = sr_q[N-1];
    assign bit_inc = bit_cnt + BW'(1);
    // bit_cnt steps on the edge ending the first LOW cycle; with CLK_DIV=1 that is also the last one
    assign bit_nxt = (div_cnt == '0) ? bit_inc : bit_cnt;
    // With CLK_DIV=1 the final shift lands on the same edge that enters DONE, so capture the
    // value the register is about to take instead of its stale output.
    assign rx_cap  = sr_shift ? {sr_q[N-2:0], sr_sdatain} : sr_q;

    // Transfer sequencer; every output except mosi is registered here
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            sclk       <= 1'b0;
            cs_n       <= 1'b1;
            sr_load    <= 1'b0;
            sr_shift   <= 1'b0;
            sr_sdatain <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rx_data    <= '0;
        end else begin
            sr_load  <= 1'b0;
            sr_shift <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        sr_load <= 1'b1;
                        busy    <= 1'b1;
                        div_cnt <= '0;
                    end
                end
                LOAD: begin
                    state   <= SETUP;
                    cs_n    <= 1'b0;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                end
                SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        state   <= HIGH;
                        sclk    <= 1'b1;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                HIGH: begin
                    if (div_cnt == '0) begin
                        sr_sdatain <= miso;
                    end
                    if (div_cnt == DIV_LAST) begin
                        state    <= LOW;
                        sclk     <= 1'b0;
                        sr_shift <= 1'b1;
                        div_cnt  <= '0;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                LOW: begin
                    bit_cnt <= bit_nxt;
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (bit_nxt == BIT_END) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            cs_n    <= 1'b1;
                            rx_data <= rx_cap;
                        end else begin
                            state <= HIGH;
                            sclk  <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cs_n  <= 1'b1;
                    sclk  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: two instances (N=8/CLK_DIV=2 and N=16/CLK_DIV=1).
// Expected receive words are queued at launch and popped when done pulses.
// All waits are bounded; DUT outputs are sampled on the falling clock edge.
module tb_spi_master_ctrl;
    logic        clk;
    logic        n_reset;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          t0 = 0;

    // instance A: N=8, CLK_DIV=2
    logic        start_a, miso_a, sr_load_a, sr_shift_a, sr_sdatain_a;
    logic        sclk_a, mosi_a, cs_n_a, busy_a, done_a;
    logic [7:0]  sr_q_a, rx_data_a, tx_a, slave_word;
    logic        loop_a;
    int          slave_bit = 0;

    // instance B: N=16, CLK_DIV=1, always loopback
    logic        start_b, miso_b, sr_load_b, sr_shift_b, sr_sdatain_b;
    logic        sclk_b, mosi_b, cs_n_b, busy_b, done_b;
    logic [15:0] sr_q_b, rx_data_b, tx_b;

    logic [15:0] exp_q[$];

    // monitor state
    logic        prev_sclk_a = 1'b0, prev_csn_a = 1'b1;
    int          rise_a = 0, shift_a = 0, done_cnt_a = 0, overlap_a = 0;
    int          cs_fall_a = 0, cs_last_a = 0;
    logic [7:0]  mosi_hist_a = 8'h00;
    logic        prev_sclk_b = 1'b0, have_rise_b = 1'b0;
    int          rise_b = 0, shift_b = 0, done_cnt_b = 0, overlap_b = 0;
    int          last_rise_b = 0, per_bad_b = 0;

    spi_master_ctrl #(.N(8), .CLK_DIV(2)) dut_a (
        .clk(clk), .n_reset(n_reset), .start(start_a), .miso(miso_a), .sr_q(sr_q_a),
        .sr_load(sr_load_a), .sr_shift(sr_shift_a), .sr_sdatain(sr_sdatain_a),
        .sclk(sclk_a), .mosi(mosi_a), .cs_n(cs_n_a), .busy(busy_a), .done(done_a),
        .rx_data(rx_data_a)
    );

    spi_master_ctrl #(.N(16), .CLK_DIV(1)) dut_b (
        .clk(clk), .n_reset(n_reset), .start(start_b), .miso(miso_b), .sr_q(sr_q_b),
        .sr_load(sr_load_b), .sr_shift(sr_shift_b), .sr_sdatain(sr_sdatain_b),
        .sclk(sclk_b), .mosi(mosi_b), .cs_n(cs_n_b), .busy(busy_b), .done(done_b),
        .rx_data(rx_data_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // external parallel/serial shift registers: load tx word, shift left taking sr_sdatain
    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) sr_q_a <= 8'h00;
        else if (sr_load_a) sr_q_a <= tx_a;
        else if (sr_shift_a) sr_q_a <= {sr_q_a[6:0], sr_sdatain_a};
    end

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) sr_q_b <= 16'h0000;
        else if (sr_load_b) sr_q_b <= tx_b;
        else if (sr_shift_b) sr_q_b <= {sr_q_b[14:0], sr_sdatain_b};
    end

    // slave for A: loopback, or a word sent MSB first that advances on each falling sclk
    always_comb begin
        miso_a = mosi_a;
        if (!loop_a) miso_a = (slave_bit < 8) ? slave_word[7 - slave_bit] : 1'b0;
    end
    assign miso_b = mosi_b;

    // monitors for both instances
    always @(negedge clk) begin
        prev_sclk_a <= sclk_a;
        prev_csn_a  <= cs_n_a;
        if (cs_n_a) slave_bit <= 0;
        else if (prev_sclk_a && !sclk_a) slave_bit <= slave_bit + 1;
        if (sclk_a && !prev_sclk_a) begin
            rise_a      <= rise_a + 1;
            mosi_hist_a <= {mosi_hist_a[6:0], mosi_a};
        end
        if (sr_shift_a) shift_a <= shift_a + 1;
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (sr_load_a && sr_shift_a) overlap_a <= overlap_a + 1;
        if (!cs_n_a && prev_csn_a) cs_fall_a <= cyc;
        if (!cs_n_a) cs_last_a <= cyc;

        prev_sclk_b <= sclk_b;
        if (sclk_b && !prev_sclk_b) begin
            rise_b      <= rise_b + 1;
            last_rise_b <= cyc;
            if (have_rise_b && (cyc - last_rise_b != 2)) per_bad_b <= per_bad_b + 1;
        end
        if (cs_n_b) have_rise_b <= 1'b0;
        else if (sclk_b && !prev_sclk_b) have_rise_b <= 1'b1;
        if (sr_shift_b) shift_b <= shift_b + 1;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
        if (sr_load_b && sr_shift_b) overlap_b <= overlap_b + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // queue the expected word and assert start on A just before edge 0
    task automatic launch(input logic [7:0] tx, input logic [7:0] sw, input logic lb);
        tx_a       = tx;
        slave_word = sw;
        loop_a     = lb;
        exp_q.push_back({8'h00, (lb ? tx : sw)});
        @(negedge clk);
        start_a = 1'b1;
        t0      = cyc;
    endtask

    // wait for done (bounded), pop the scoreboard and compare; returns done cycle relative to t0
    task automatic finish_xfer(input logic use_b, input int poke, input logic hold, output int rel);
        logic        got;
        logic [15:0] e;
        logic [15:0] rx;
        int          n;
        got = 1'b0;
        n   = 0;
        rel = -1;
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            if (!hold) begin
                start_a = (poke > 0) && (cyc - t0 == poke);
                start_b = 1'b0;
            end
            if (use_b ? done_b : done_a) begin
                got = 1'b1;
                rel = cyc - t0;
            end
        end
        chk("done_seen", got, 1);
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (got && exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            rx = use_b ? rx_data_b : {8'h00, rx_data_a};
            chk("rx_data", rx, e);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel, r0, s0, d0, n;
        n_reset = 1'b0;
        start_a = 1'b1;
        start_b = 1'b1;
        tx_a = 8'h00; tx_b = 16'h0000; slave_word = 8'h00; loop_a = 1'b1;

        // reset held with start asserted: outputs at reset values, busy never rises
        repeat (4) begin
            @(negedge clk);
            chk("rst_busy", busy_a, 0);
        end
        chk("rst_sclk", sclk_a, 0);
        chk("rst_cs_n", cs_n_a, 1);
        chk("rst_load", sr_load_a, 0);
        chk("rst_shift", sr_shift_a, 0);
        chk("rst_sdatain", sr_sdatain_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_rx", rx_data_a, 0);
        chk("rst_b_busy", busy_b, 0);
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        repeat (3) @(negedge clk);

        // loopback A5: latency 36, 8 rising edges, cs_n low for cycles 2..35
        r0 = rise_a; s0 = shift_a; d0 = done_cnt_a;
        launch(8'hA5, 8'h00, 1'b1);
        finish_xfer(1'b0, 0, 1'b0, rel);
        chk("lat_a5", rel, 36);
        repeat (4) @(negedge clk);
        chk("rises_a5", rise_a - r0, 8);
        chk("shifts_a5", shift_a - s0, 8);
        chk("dones_a5", done_cnt_a - d0, 1);
        chk("cs_first", cs_fall_a - t0, 2);
        chk("cs_last", cs_last_a - t0, 35);
        chk("busy_after", busy_a, 0);

        // slave returns 3C while master sends C3
        r0 = rise_a;
        launch(8'hC3, 8'h3C, 1'b0);
        finish_xfer(1'b0, 0, 1'b0, rel);
        repeat (3) @(negedge clk);
        chk("mosi_seq", mosi_hist_a, 8'hC3);
        chk("rises_c3", rise_a - r0, 8);

        // start pulsed mid-transfer is ignored
        d0 = done_cnt_a;
        launch(8'h96, 8'h00, 1'b1);
        finish_xfer(1'b0, 10, 1'b0, rel);
        chk("lat_poke", rel, 36);
        repeat (60) @(negedge clk);
        chk("dones_poke", done_cnt_a - d0, 1);
        chk("busy_poke", busy_a, 0);
        chk("sb_empty", exp_q.size(), 0);

        // start held through DONE: next LOAD in cycle 38, second done in cycle 73
        launch(8'h1E, 8'h00, 1'b1);
        exp_q.push_back(16'h001E);
        finish_xfer(1'b0, 0, 1'b1, rel);
        chk("lat_b2b1", rel, 36);
        @(negedge clk);
        chk("b2b_idle_busy", busy_a, 0);
        chk("b2b_idle_load", sr_load_a, 0);
        @(negedge clk);
        chk("b2b_load", sr_load_a, 1);
        chk("b2b_load_cyc", cyc - t0, 38);
        start_a = 1'b0;
        finish_xfer(1'b0, 0, 1'b0, rel);
        chk("lat_b2b2", rel, 73);

        // receive 00 so rx_data matches its reset value, then abort after bit 4
        launch(8'hFF, 8'h00, 1'b0);
        finish_xfer(1'b0, 0, 1'b0, rel);
        repeat (3) @(negedge clk);
        s0 = shift_a;
        launch(8'h69, 8'hB4, 1'b0);
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (shift_a - s0 < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached", n < 200, 1);
        d0 = done_cnt_a;
        n_reset = 1'b0;
        #1;
        chk("abort_sclk", sclk_a, 0);
        chk("abort_cs_n", cs_n_a, 1);
        chk("abort_busy", busy_a, 0);
        chk("abort_rx", rx_data_a, 0);
        void'(exp_q.pop_back());
        @(negedge clk);
        n_reset = 1'b1;
        repeat (60) @(negedge clk);
        chk("abort_no_done", done_cnt_a - d0, 0);
        chk("abort_rx_hold", rx_data_a, 0);
        launch(8'hD2, 8'h4B, 1'b0);
        finish_xfer(1'b0, 0, 1'b0, rel);
        chk("lat_after_abort", rel, 36);

        // CLK_DIV=1, N=16 loopback of 8001: latency 35, sclk period 2, 16 shifts
        r0 = rise_b; s0 = shift_b; d0 = done_cnt_b;
        tx_b = 16'h8001;
        exp_q.push_back(16'h8001);
        @(negedge clk);
        start_b = 1'b1;
        t0 = cyc;
        finish_xfer(1'b1, 0, 1'b0, rel);
        chk("lat_b", rel, 35);
        repeat (4) @(negedge clk);
        chk("rises_b", rise_b - r0, 16);
        chk("shifts_b", shift_b - s0, 16);
        chk("period_b", per_bad_b, 0);
        chk("dones_b", done_cnt_b - d0, 1);
        chk("busy_b_after", busy_b, 0);
        chk("overlap_a", overlap_a, 0);
        chk("overlap_b", overlap_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
